// File: rtl/mem_port_arbiter.sv
// Two-master arbiter (instruction fetch vs load/store) in front of a single-port
// synchronous memory, with anti-starvation for fetch and read-data return routing.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_LS = 2'd2
    } rd_state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    rd_state_t  state_reg, state_next;
    logic [2:0] streak_reg, streak_next;
    logic       ls_err_reg, ls_err_next;

    logic tick;
    logic ls_aligned;
    logic ls_wins;

    assign tick       = clk_enable & ~rst;
    assign ls_aligned = (ls_addr[1:0] == 2'b00);
    // Load/store has priority unless fetch has been passed over LIMIT times in a row.
    assign ls_wins    = ls_req & (~if_req | (streak_reg != LIMIT));

    assign ls_gnt = tick & ls_wins;
    assign if_gnt = tick & if_req & ~ls_wins;

    assign mem_addr  = if_gnt ? if_addr : (ls_gnt ? ls_addr : 32'd0);
    assign mem_we    = ls_gnt & ls_we & ls_aligned;
    assign mem_wdata = ls_gnt ? ls_wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            streak_reg <= 3'd0;
            ls_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
            ls_err_reg <= ls_err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        streak_next = streak_reg;
        ls_err_next = ls_err_reg;
        if (tick) begin
            if (if_gnt) begin
                state_next = RD_IF;
            end else if (ls_gnt && !ls_we && ls_aligned) begin
                state_next = RD_LS;
            end else begin
                state_next = IDLE;
            end

            if (if_gnt || !if_req) begin
                streak_next = 3'd0;
            end else if (ls_gnt && streak_reg != LIMIT) begin
                streak_next = streak_reg + 3'd1;
            end

            ls_err_next = ls_gnt & ~ls_aligned;
        end
    end

    // Registered status is masked while reset is held so nothing leaks out mid-reset.
    assign if_rvalid = ~rst & (state_reg == RD_IF);
    assign ls_rvalid = ~rst & (state_reg == RD_LS);
    assign ls_err    = ~rst & ls_err_reg;
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of one-tick transactions
// followed by hand-written contention and reset-mid-read sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        clk_enable;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {if_gnt, ls_gnt, mem_we, if_rvalid, ls_rvalid, ls_err}
    typedef struct {
        string       name;
        logic        rst;
        logic        ce;
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [31:0] mem_rdata;
        logic [5:0]  flags;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] if_rdata;
        logic [31:0] ls_rdata;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(string name, logic r, logic ce, logic ifr, logic [31:0] ifa,
                                logic lsr, logic lswe, logic [31:0] lsa, logic [31:0] lsd,
                                logic [31:0] mrd, logic [5:0] fl, logic [31:0] ma,
                                logic [31:0] mwd, logic [31:0] ird, logic [31:0] lrd);
        vec_t v;
        v.name = name; v.rst = r; v.ce = ce; v.if_req = ifr; v.if_addr = ifa;
        v.ls_req = lsr; v.ls_we = lswe; v.ls_addr = lsa; v.ls_wdata = lsd;
        v.mem_rdata = mrd; v.flags = fl; v.mem_addr = ma; v.mem_wdata = mwd;
        v.if_rdata = ird; v.ls_rdata = lrd;
        return v;
    endfunction

    function automatic logic [133:0] outs();
        return {if_gnt, ls_gnt, mem_we, if_rvalid, ls_rvalid, ls_err,
                mem_addr, mem_wdata, if_rdata, ls_rdata};
    endfunction

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic r, input logic ce, input logic ifr, input logic [31:0] ifa,
                         input logic lsr, input logic lswe, input logic [31:0] lsa,
                         input logic [31:0] lsd, input logic [31:0] mrd);
        rst = r; clk_enable = ce; if_req = ifr; if_addr = ifa;
        ls_req = lsr; ls_we = lswe; ls_addr = lsa; ls_wdata = lsd; mem_rdata = mrd;
    endtask

    // Contention run: both request continuously, expected grant pattern given as L/I chars.
    task automatic contention(input string tag, input string pattern, input byte prev_in);
        byte prev;
        prev = prev_in;
        for (int i = 0; i < pattern.len(); i++) begin
            logic        exp_if, exp_ls;
            logic [31:0] exp_addr;
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0);
            #1;
            exp_if   = (pattern[i] == "I");
            exp_ls   = (pattern[i] == "L");
            exp_addr = exp_if ? 32'h300 : 32'h400;
            check($sformatf("%s_tick%0d", tag, i),
                  {96'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_addr},
                  {96'd0, exp_if, exp_ls, prev == "I", prev == "L", exp_addr});
            prev = pattern[i];
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        vecs[0]  = mk("rst_hold_a",   1, 1, 1, 32'h100, 1, 0, 32'h40, 32'h0, 32'h0BADF00D,
                      6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1]  = mk("rst_hold_b",   1, 1, 1, 32'h100, 1, 0, 32'h40, 32'h0, 32'h0BADF00D,
                      6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[2]  = mk("fetch_grant",  0, 1, 1, 32'h100, 0, 0, 32'h0, 32'h0, 32'h0,
                      6'b100000, 32'h100, 32'h0, 32'h0, 32'h0);
        vecs[3]  = mk("fetch_rdata",  0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF,
                      6'b000100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        vecs[4]  = mk("store",        0, 1, 0, 32'h0, 1, 1, 32'h40, 32'h12345678, 32'hAAAA5555,
                      6'b011000, 32'h40, 32'h12345678, 32'h0, 32'h0);
        vecs[5]  = mk("store_misal",  0, 1, 0, 32'h0, 1, 1, 32'h42, 32'hCAFEF00D, 32'h0,
                      6'b010000, 32'h42, 32'hCAFEF00D, 32'h0, 32'h0);
        vecs[6]  = mk("err_pulse",    0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0,
                      6'b000001, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk("err_clear",    0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0,
                      6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk("load_a",       0, 1, 0, 32'h0, 1, 0, 32'h80, 32'h0, 32'h0,
                      6'b010000, 32'h80, 32'h0, 32'h0, 32'h0);
        vecs[9]  = mk("load_b_pipe",  0, 1, 0, 32'h0, 1, 0, 32'h84, 32'h0, 32'h11112222,
                      6'b010010, 32'h84, 32'h0, 32'h0, 32'h11112222);
        vecs[10] = mk("ce_off_0",     0, 0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 32'h33334444,
                      6'b000010, 32'h0, 32'h0, 32'h0, 32'h33334444);
        vecs[11] = mk("ce_off_1",     0, 0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 32'h33334444,
                      6'b000010, 32'h0, 32'h0, 32'h0, 32'h33334444);
        vecs[12] = mk("ce_off_2",     0, 0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 32'h33334444,
                      6'b000010, 32'h0, 32'h0, 32'h0, 32'h33334444);
        vecs[13] = mk("ce_off_3",     0, 0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 32'h33334444,
                      6'b000010, 32'h0, 32'h0, 32'h0, 32'h33334444);
        vecs[14] = mk("ce_on_fetch",  0, 1, 1, 32'h200, 0, 0, 32'h0, 32'h0, 32'h55556666,
                      6'b100010, 32'h200, 32'h0, 32'h0, 32'h55556666);
        vecs[15] = mk("fetch_rdata2", 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h77778888,
                      6'b000100, 32'h0, 32'h0, 32'h77778888, 32'h0);
        vecs[16] = mk("load_misal",   0, 1, 0, 32'h0, 1, 0, 32'h81, 32'h0, 32'h0,
                      6'b010000, 32'h81, 32'h0, 32'h0, 32'h0);
        vecs[17] = mk("load_misal_e", 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h9999AAAA,
                      6'b000001, 32'h0, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ce, vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req,
                  vecs[i].ls_we, vecs[i].ls_addr, vecs[i].ls_wdata, vecs[i].mem_rdata);
            #1;
            check(vecs[i].name, outs(),
                  {vecs[i].flags, vecs[i].mem_addr, vecs[i].mem_wdata,
                   vecs[i].if_rdata, vecs[i].ls_rdata});
        end

        // Fetch gets in after three consecutive load/store wins.
        contention("contend", "LLLILLLI", "N");

        // Build up a streak of 2, then reset while a load is outstanding.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0);
        #1;
        check("pre_rst_ls0", {126'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, 4'd0},
              {126'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0});
        @(negedge clk);
        #1;
        check("pre_rst_ls1", {126'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, 4'd0},
              {126'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0});
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h500, 32'h0, 32'h12121212);
        #1;
        check("rst_mid_read", outs(), 134'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h34343434);
        #1;
        check("post_rst_idle", outs(), 134'd0);

        // A cleared streak means three load/store wins again before fetch.
        contention("post_rst", "LLLI", "N");

        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 3, max consecutive load/store grants while fetch waits (range 1..7).
REQ-002 clk  in  1  system clock; one clock, all state on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 clk_enable  in  1  CPU tick qualifier; "tick" = rising clk edge with clk_enable=1; state changes only on ticks.
REQ-005 if_req  in  1  instruction-fetch read request.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch granted this tick (combinational).
REQ-008 if_rvalid  out  1  fetch read data valid.
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 ls_req  in  1  load/store request.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_addr  in  32  load/store byte address.
REQ-013 ls_wdata  in  32  store data.
REQ-014 ls_gnt  out  1  load/store granted this tick (combinational).
REQ-015 ls_rvalid  out  1  load read data valid.
REQ-016 ls_rdata  out  32  load read data.
REQ-017 ls_err  out  1  misaligned access flag.
REQ-018 mem_addr  out  32  address to the single-port memory.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid one tick after address presented.

Function
REQ-022 Grant: at most one of if_gnt/ls_gnt high; neither high when rst=1 or clk_enable=0.
REQ-023 Priority: ls wins when both request, unless streak counter == STARVE_LIMIT, then if wins.
REQ-024 Streak counter (3 bits): +1 on tick with ls_gnt while if_req=1; clears on tick with if_gnt or with if_req=0; saturates at STARVE_LIMIT.
REQ-025 mem_addr = granted requester's address; 0 when no grant; mem_wdata = ls_wdata when ls_gnt, else 0.
REQ-026 mem_we = ls_gnt & ls_we & (ls_addr[1:0]==0).
REQ-027 Read-owner FSM states: IDLE, RD_IF, RD_LS; on each tick next state = RD_IF if if_gnt, RD_LS if ls_gnt & !ls_we & aligned, else IDLE.
REQ-028 if_rvalid = (state==RD_IF); ls_rvalid = (state==RD_LS); if_rdata/ls_rdata = mem_rdata while own rvalid high, else 0.
REQ-029 Latency: read data valid for the whole tick period following the grant tick; back-to-back grants give one access per tick with no bubble.
REQ-030 New grant permitted in the same tick rvalid is high (pipelined).
REQ-031 Stores complete at the grant tick; no rvalid; ls_gnt is the acknowledgement.
REQ-032 Misaligned ls (ls_addr[1:0]!=0): ls_gnt still asserted (request consumed), no mem write, no rvalid; ls_err high for the following tick period, else 0.
REQ-033 Requests sampled only at ticks; requester holds req/addr/data stable until its gnt.

Reset
REQ-034 On rst tick-independent (any clk edge with rst=1): state=IDLE, streak=0, ls_err=0; all outputs 0 during and after reset until next grant.
REQ-035 Reset mid-read discards the outstanding read: no rvalid issued after reset.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x100, mem_rdata=0xDEADBEEF next tick -> if_gnt at tick 0, if_rvalid=1 & if_rdata=0xDEADBEEF at tick 1.
REQ-037 Contention: if_req=ls_req=1 continuously, ls_we=0, STARVE_LIMIT=3 -> grant pattern ls,ls,ls,if,ls,ls,ls,if.
REQ-038 Store: ls_req=1, ls_we=1, ls_addr=0x40, ls_wdata=0x12345678 -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 in grant tick, no ls_rvalid.
REQ-039 Misaligned: ls_addr=0x42, ls_we=1 -> ls_gnt=1, mem_we=0, ls_err=1 next tick only.
REQ-040 Reset mid-read: load granted at tick N, rst=1 before tick N+1 -> ls_rvalid=0, state IDLE, streak 0.
REQ-041 clk_enable=0 for 4 clocks with if_req=1 -> no grant, no state change, mem_addr=0.
